data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 80 ++++++++
 tb/tb_data_mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester arbiter in front of a registered-read data memory.
// Define DATA_MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to A.
module data_mem_arbiter #(
  parameter logic [7:0] BASE_ADDR = 8'd64,
  parameter int         DEPTH     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] addr_a,
  input  logic [7:0] wdata_a,
  output logic       gnt_a,
  output logic       rvalid_a,
  output logic [7:0] rdata_a,
  output logic       err_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_b,
  output logic       gnt_b,
  output logic       rvalid_b,
  output logic [7:0] rdata_b,
  output logic       err_b,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [8:0] LAST = 9'(int'(BASE_ADDR) + DEPTH - 1);
  state_t     state, state_nx;
  logic       win_b, lat_we, sel_b, in_win, take, issue, resp;
  logic [7:0] lat_addr, lat_wdata;
  assign take = state == IDLE && (req_a || req_b);
  assign in_win = lat_addr >= BASE_ADDR && {1'b0, lat_addr} <= LAST;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  logic last_b;
  assign sel_b = req_b && (!req_a || !last_b);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_b <= 1'b1;
    else if (take) last_b <= sel_b;
`else
  assign sel_b = req_b && !req_a;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (take ? ISSUE : IDLE) :
               state == ISSUE ? (!lat_we && in_win ? RESP : IDLE) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_b     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 8'h00;
    end else if (take) begin
      win_b     <= sel_b;
      lat_we    <= sel_b ? we_b : we_a;
      lat_addr  <= sel_b ? addr_b : addr_a;
      lat_wdata <= sel_b ? wdata_b : wdata_a;
    end
  // rst_n gates mem_we directly so a write in flight is dropped the instant reset asserts
  always_comb begin
    issue     = state == ISSUE;
    resp      = state == RESP;
    gnt_a     = issue && !win_b;
    gnt_b     = issue && win_b;
    err_a     = gnt_a && !in_win;
    err_b     = gnt_b && !in_win;
    mem_we    = rst_n && issue && lat_we && in_win;
    mem_addr  = issue ? lat_addr : 8'h00;
    mem_wdata = issue ? lat_wdata : 8'h00;
    rvalid_a  = resp && !win_b;
    rvalid_b  = resp && win_b;
    rdata_a   = rvalid_a ? mem_rdata : 8'h00;
    rdata_b   = rvalid_b ? mem_rdata : 8'h00;
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter with a behavioural memory.
module tb_data_mem_arbiter;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [7:0] addr_a = 8'h00, wdata_a = 8'h00, addr_b = 8'h00, wdata_b = 8'h00;
  logic       gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b, mem_we;
  logic [7:0] rdata_a, rdata_b, mem_addr, mem_wdata;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] mem_rdata = 8'h00;
  int checks = 0, errors = 0;
  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a), .err_a(err_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b), .err_b(err_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else mem_rdata <= mem[mem_addr];
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic b, input logic we, input logic [7:0] a, input logic [7:0] wd);
    if (b) begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = wd; end
    else begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = wd; end
  endtask
  task automatic xact(input logic b, input logic we, input logic [7:0] a, input logic [7:0] wd,
                      input logic [7:0] rd, input logic e);
    drive(b, we, a, wd);
    step();
    chk("gnt_a", 8'(gnt_a), 8'(!b));
    chk("gnt_b", 8'(gnt_b), 8'(b));
    chk("err_a", 8'(err_a), 8'(!b && e));
    chk("err_b", 8'(err_b), 8'(b && e));
    chk("mem_we", 8'(mem_we), 8'(we && !e));
    chk("mem_addr", mem_addr, a);
    if (we && !e) chk("mem_wdata", mem_wdata, wd);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    if (!we && !e) begin
      chk("rvalid_a", 8'(rvalid_a), 8'(!b));
      chk("rvalid_b", 8'(rvalid_b), 8'(b));
      chk("rdata", b ? rdata_b : rdata_a, rd);
      step();
    end
    chk("idle_gnt", 8'({gnt_a, gnt_b}), 8'h00);
    chk("idle_rvalid", 8'({rvalid_a, rvalid_b}), 8'h00);
    chk("idle_we", 8'(mem_we), 8'h00);
  endtask
  initial begin
    #12;
    chk("rst_gnt", 8'({gnt_a, gnt_b, err_a, err_b}), 8'h00);
    chk("rst_rvalid", 8'({rvalid_a, rvalid_b, mem_we}), 8'h00);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rdata", rdata_a | rdata_b, 8'h00);
    rst_n = 1'b1;
    xact(1'b0, 1'b1, 8'd70, 8'hA5, 8'h00, 1'b0);
    xact(1'b1, 1'b0, 8'd70, 8'h00, 8'hA5, 1'b0);
    xact(1'b0, 1'b1, 8'd64, 8'h11, 8'h00, 1'b0);
    xact(1'b1, 1'b1, 8'd127, 8'h22, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'd64, 8'h00);
    drive(1'b1, 1'b0, 8'd127, 8'h00);
    for (int k = 0; k < 4; k++) begin
      automatic logic exp_b = RR && k[0];
      step();
      chk("tie_gnt_a", 8'(gnt_a), 8'(!exp_b));
      chk("tie_gnt_b", 8'(gnt_b), 8'(exp_b));
      step();
      chk("tie_rvalid_a", 8'(rvalid_a), 8'(!exp_b));
      chk("tie_rvalid_b", 8'(rvalid_b), 8'(exp_b));
      chk("tie_rdata", exp_b ? rdata_b : rdata_a, exp_b ? 8'h22 : 8'h11);
      step();
      chk("tie_idle", 8'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 8'h00);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    xact(1'b0, 1'b0, 8'd63, 8'h00, 8'h00, 1'b1);
    xact(1'b0, 1'b1, 8'd128, 8'h5A, 8'h00, 1'b1);
    xact(1'b1, 1'b0, 8'd200, 8'h00, 8'h00, 1'b1);
    xact(1'b0, 1'b0, 8'd127, 8'h00, 8'h22, 1'b0);
    drive(1'b0, 1'b0, 8'd70, 8'h00);
    step();
    req_a = 1'b0;
    step();
    chk("pre_rst_rvalid", 8'(rvalid_a), 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rvalid", 8'({rvalid_a, rvalid_b}), 8'h00);
    chk("rst_resp_rdata", rdata_a, 8'h00);
    chk("rst_resp_addr", mem_addr, 8'h00);
    #12 rst_n = 1'b1;
    step();
    chk("post_rst_quiet", 8'({gnt_a, gnt_b, rvalid_a, rvalid_b}), 8'h00);
    drive(1'b0, 1'b0, 8'd64, 8'h00);
    drive(1'b1, 1'b0, 8'd127, 8'h00);
    step();
    chk("post_rst_tie_a", 8'(gnt_a), 8'h01);
    chk("post_rst_tie_b", 8'(gnt_b), 8'h00);
    req_a = 1'b0;
    req_b = 1'b0;
    step();
    chk("post_rst_rdata", rdata_a, 8'h11);
    step();
    xact(1'b0, 1'b0, 8'd70, 8'h00, 8'hA5, 1'b0);
    drive(1'b0, 1'b1, 8'd90, 8'h77);
    step();
    chk("issue_we", 8'(mem_we), 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_issue_we", 8'(mem_we), 8'h00);
    req_a = 1'b0;
    #12 rst_n = 1'b1;
    step();
    xact(1'b1, 1'b0, 8'd90, 8'h00, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
